servo_duty_sequencer: RTL
=========================

Name: servo_duty_sequencer

Overview:
- Parametrised duty-pattern generator for the pan/tilt servo PWM path.
- Produces NUM_CH duty words under one of four modes: HOLD, TOGGLE, RAMP or TRIANGLE.
- Advances the pattern once per programmable dwell interval.
- Hands each new duty set to the PWM stage over a valid/ready handshake.
- Used for bring-up, calibration sweeps and bench stimulus in place of the tracker's blob-center output.

Parameters:
- NUM_CH, 2, number of servo channels driven (pan, tilt, ...).
- DUTY_W, 8, duty word width in bits.
- DWELL_W, 32, width of the dwell counter and iDwell.
- MIRROR_ODD, 0, when 1 odd channels output iLow+iHigh-v (mirrored); even channels always output v.

Ports:
- iClock  in  1  system clock.
- iReset  in  1  synchronous, active-low reset.
- iEnable  in  1  run request; level-sensitive.
- iMode  in  2  0=HOLD, 1=TOGGLE, 2=RAMP, 3=TRIANGLE.
- iDwell  in  DWELL_W  clocks between pattern updates.
- iLow  in  DUTY_W  pattern minimum.
- iHigh  in  DUTY_W  pattern maximum.
- iStep  in  DUTY_W  RAMP/TRIANGLE increment.
- iReady  in  1  PWM stage accepts oDuty.
- oDuty  out  NUM_CH*DUTY_W  packed duties, channel 0 in LSBs.
- oValid  out  1  oDuty holds a new, unaccepted update.
- oPeriod  out  1  one-cycle pulse when the pattern completes a period.
- oBusy  out  1  state != IDLE.

Behaviour:
- Reset is synchronous, active-low, on iReset; clock is iClock.
- Reset values: oDuty=0, oValid=0, oPeriod=0, oBusy=0, counter=0, dir=up, state=IDLE.
- States:
  - IDLE:
    - If iEnable=1, latch config: mode, dwell, low, high, step.
    - Sanitise: dwell 0 becomes 1; step 0 becomes 1; if iLow>iHigh, high=low.
    - Next cycle: v=low, dir=up, oValid=1, go to WAIT_ACK.
  - RUN:
    - counter++ each cycle.
    - When counter==dwell-1: counter=0, compute next v, oValid=1, go to WAIT_ACK.
    - An update therefore issues every dwell clocks after the previous acceptance.
  - WAIT_ACK:
    - oDuty and oValid hold stable and the counter stalls.
    - On oValid&iReady: oValid=0 the next cycle, go to RUN.
    - A stalled consumer never loses or skips an update.
- Config changes are ignored outside IDLE.
- Next-value rules (all arithmetic in DUTY_W+1 bits; no overflow):
  - HOLD: v=low. The value is reissued each dwell. oPeriod fires every update.
  - TOGGLE: low->high->low. oPeriod fires on the return to low.
  - RAMP: v+step if that is <= high, else wrap to low. oPeriod fires on the wrap.
  - TRIANGLE, dir up: if v+step >= high, then v=high and dir=down; else v=v+step.
  - TRIANGLE, dir down: if v < low+step, then v=low, dir=up and oPeriod fires; else v=v-step.
  - oPeriod is asserted in the same cycle oValid rises with the period-closing value.
- Per channel c: duty = v; if MIRROR_ODD=1 and c is odd, duty = low+high-v. The result stays within [low,high].
- iEnable deasserted:
  - In RUN: go to IDLE next cycle; oDuty retains its last value; counter=0.
  - In WAIT_ACK: complete the handshake first, then go to IDLE. oValid never drops without an accept.
- low==high: every mode outputs constant low; oPeriod fires every update.

Decomposition:
- Shared package motion_pkg:
  - Typedef duty_mode_e (HOLD/TOGGLE/RAMP/TRIANGLE).
  - Typedef seq_state_e (IDLE/RUN/WAIT_ACK).
  - Default servo duty constants.
- One sub-module, duty_step_calc: combinational next-value, dir and period-flag logic from (mode, v, dir, low, high, step).
- The sequencer keeps the FSM, dwell counter, config latch and channel mirroring.

Test Plan:
- Reset check:
  - Stimulus: hold iReset=0 for 3 cycles with iEnable=1.
  - Required: oDuty=0, oValid=0, oBusy=0.
  - Release reset: first oDuty=0x00 (low) with oValid=1 two cycles later.
- TOGGLE, dwell and mirroring:
  - Stimulus: iReady=1, low=0x00, high=0x28, dwell=4, MIRROR_ODD=1.
  - Required: ch0 sequence 00,28,00,28 with updates exactly 4 clocks apart after each accept.
  - ch1 outputs 28,00,28,00.
  - oPeriod fires on each return to 00.
- RAMP wrap:
  - Stimulus: low=0x10, high=0x30, step=0x0C, dwell=1.
  - Required: 10,1C,28,10,... ; oPeriod fires on the 28->10 wrap.
  - Boundary: high=0xFF, step=0x80, low=0x00 gives 00,80,00 (no 8-bit overflow).
- TRIANGLE reversal:
  - Stimulus: low=0x00, high=0x20, step=0x0C.
  - Required: 00,0C,18,20,14,08,00,0C.
  - Required: dir flips at 20; oPeriod fires at the return to 00.
- Backpressure:
  - Stimulus: iReady=0 for 20 cycles with dwell=2.
  - Required: oValid and oDuty stay stable; no update is skipped.
  - After iReady=1: the next value follows the stalled one, 2 clocks after the accept.
- Disable mid-handshake and degenerate config:
  - Stimulus: drop iEnable while oValid=1.
  - Required: oValid holds until iReady, then IDLE; oBusy=0.
  - Stimulus: enable with dwell=0, step=0, low=0x30, high=0x10.
  - Required: behaves as dwell=1, step=1, constant 0x30 output.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared motion-control types for servo pattern generation: duty modes,
// sequencer state encodings and default servo duty words.
package motion_pkg;

   typedef enum logic [1:0] {
      DUTY_HOLD     = 2'd0,
      DUTY_TOGGLE   = 2'd1,
      DUTY_RAMP     = 2'd2,
      DUTY_TRIANGLE = 2'd3
   } duty_mode_e;

   typedef enum logic [1:0] {
      SEQ_IDLE     = 2'd0,
      SEQ_RUN      = 2'd1,
      SEQ_WAIT_ACK = 2'd2
   } seq_state_e;

   localparam logic [7:0] SERVO_DUTY_MIN    = 8'h00;
   localparam logic [7:0] SERVO_DUTY_CENTER = 8'h80;
   localparam logic [7:0] SERVO_DUTY_MAX    = 8'hFF;

endpackage

// File: rtl/duty_step_calc.sv
// Combinational next-value, direction and period-closing logic for one
// step of the duty pattern.
module duty_step_calc
   import motion_pkg::*;
#(
   parameter int DUTY_W = 8
) (
   input  duty_mode_e        mode,
   input  logic [DUTY_W-1:0] v,
   input  logic              dir_down,
   input  logic [DUTY_W-1:0] low,
   input  logic [DUTY_W-1:0] high,
   input  logic [DUTY_W-1:0] step,
   output logic [DUTY_W-1:0] next_v,
   output logic              next_dir_down,
   output logic              period
);

   logic [DUTY_W:0] sum_s;
   logic [DUTY_W:0] low_step_s;

   // Next pattern value; sums carry one extra bit so v+step never wraps.
   always_comb begin
      sum_s         = {1'b0, v} + {1'b0, step};
      low_step_s    = {1'b0, low} + {1'b0, step};
      next_v        = low;
      next_dir_down = 1'b0;
      period        = 1'b0;
      if (low == high) begin
         next_v        = low;
         next_dir_down = 1'b0;
         period        = 1'b1;
      end else begin
         case (mode)
            DUTY_HOLD: begin
               next_v = low;
               period = 1'b1;
            end
            DUTY_TOGGLE: begin
               if (v == low) begin
                  next_v = high;
                  period = 1'b0;
               end else begin
                  next_v = low;
                  period = 1'b1;
               end
            end
            DUTY_RAMP: begin
               if (sum_s <= {1'b0, high}) begin
                  next_v = sum_s[DUTY_W-1:0];
                  period = 1'b0;
               end else begin
                  next_v = low;
                  period = 1'b1;
               end
            end
            DUTY_TRIANGLE: begin
               if (!dir_down) begin
                  if (sum_s >= {1'b0, high}) begin
                     next_v        = high;
                     next_dir_down = 1'b1;
                  end else begin
                     next_v        = sum_s[DUTY_W-1:0];
                     next_dir_down = 1'b0;
                  end
               end else begin
                  if ({1'b0, v} < low_step_s) begin
                     next_v        = low;
                     next_dir_down = 1'b0;
                     period        = 1'b1;
                  end else begin
                     next_v        = v - step;
                     next_dir_down = 1'b1;
                  end
               end
            end
            default: begin
               next_v = low;
               period = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/servo_duty_sequencer.sv
// Duty-pattern sequencer for the servo PWM path: config latch, dwell timer,
// valid/ready hand-off and optional mirroring of odd channels.
module servo_duty_sequencer
   import motion_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int DUTY_W     = 8,
   parameter int DWELL_W    = 32,
   parameter bit MIRROR_ODD = 1'b0
) (
   input  logic                     iClock,
   input  logic                     iReset,
   input  logic                     iEnable,
   input  logic [1:0]               iMode,
   input  logic [DWELL_W-1:0]       iDwell,
   input  logic [DUTY_W-1:0]        iLow,
   input  logic [DUTY_W-1:0]        iHigh,
   input  logic [DUTY_W-1:0]        iStep,
   input  logic                     iReady,
   output logic [NUM_CH*DUTY_W-1:0] oDuty,
   output logic                     oValid,
   output logic                     oPeriod,
   output logic                     oBusy
);

   localparam logic [1:0] ST_IDLE     = 2'(SEQ_IDLE);
   localparam logic [1:0] ST_RUN      = 2'(SEQ_RUN);
   localparam logic [1:0] ST_WAIT_ACK = 2'(SEQ_WAIT_ACK);

   localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
   localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
   localparam logic [DUTY_W-1:0]  DUTY_ZERO  = {DUTY_W{1'b0}};
   localparam logic [DUTY_W-1:0]  DUTY_ONE   = {{(DUTY_W-1){1'b0}}, 1'b1};

   logic [1:0]               state_r;
   logic                     start_r;
   duty_mode_e               mode_r;
   logic [DWELL_W-1:0]       dwell_r;
   logic [DUTY_W-1:0]        low_r;
   logic [DUTY_W-1:0]        high_r;
   logic [DUTY_W-1:0]        step_r;
   logic [DUTY_W-1:0]        v_r;
   logic                     dir_down_r;
   logic [DWELL_W-1:0]       count_r;
   logic [NUM_CH*DUTY_W-1:0] duty_r;
   logic                     valid_r;
   logic                     period_r;
   logic                     busy_r;

   logic [DWELL_W-1:0]       dwell_san_s;
   logic [DUTY_W-1:0]        step_san_s;
   logic [DUTY_W-1:0]        high_san_s;
   logic [DUTY_W-1:0]        next_v_s;
   logic                     next_dir_down_s;
   logic                     next_period_s;
   logic [DUTY_W-1:0]        issue_v_s;
   logic [DUTY_W-1:0]        mirror_s;
   logic [NUM_CH*DUTY_W-1:0] pack_s;

   duty_step_calc #(
      .DUTY_W (DUTY_W)
   ) u_step_calc (
      .mode          (mode_r),
      .v             (v_r),
      .dir_down      (dir_down_r),
      .low           (low_r),
      .high          (high_r),
      .step          (step_r),
      .next_v        (next_v_s),
      .next_dir_down (next_dir_down_s),
      .period        (next_period_s)
   );

   // Degenerate configurations are repaired before they are latched.
   always_comb begin
      if (iDwell == DWELL_ZERO) begin
         dwell_san_s = DWELL_ONE;
      end else begin
         dwell_san_s = iDwell;
      end
      if (iStep == DUTY_ZERO) begin
         step_san_s = DUTY_ONE;
      end else begin
         step_san_s = iStep;
      end
      if (iLow > iHigh) begin
         high_san_s = iLow;
      end else begin
         high_san_s = iHigh;
      end
   end

   // Value about to be issued and its per-channel (optionally mirrored) packing.
   // The mirror stays inside [low,high], so modular DUTY_W-bit math is exact.
   always_comb begin
      if (state_r == ST_IDLE) begin
         issue_v_s = low_r;
      end else begin
         issue_v_s = next_v_s;
      end
      mirror_s = low_r + high_r - issue_v_s;
      pack_s   = {(NUM_CH*DUTY_W){1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         if (MIRROR_ODD && c[0]) begin
            pack_s[c*DUTY_W +: DUTY_W] = mirror_s;
         end else begin
            pack_s[c*DUTY_W +: DUTY_W] = issue_v_s;
         end
      end
   end

   // Sequencer FSM, config latch, dwell counter and output registers.
   always_ff @(posedge iClock) begin
      if (!iReset) begin
         state_r    <= ST_IDLE;
         start_r    <= 1'b0;
         mode_r     <= DUTY_HOLD;
         dwell_r    <= DWELL_ONE;
         low_r      <= DUTY_ZERO;
         high_r     <= DUTY_ZERO;
         step_r     <= DUTY_ONE;
         v_r        <= DUTY_ZERO;
         dir_down_r <= 1'b0;
         count_r    <= DWELL_ZERO;
         duty_r     <= {(NUM_CH*DUTY_W){1'b0}};
         valid_r    <= 1'b0;
         period_r   <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         period_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               count_r <= DWELL_ZERO;
               if (start_r) begin
                  start_r    <= 1'b0;
                  v_r        <= low_r;
                  dir_down_r <= 1'b0;
                  duty_r     <= pack_s;
                  valid_r    <= 1'b1;
                  state_r    <= ST_WAIT_ACK;
                  busy_r     <= 1'b1;
               end else if (iEnable) begin
                  start_r <= 1'b1;
                  mode_r  <= duty_mode_e'(iMode);
                  dwell_r <= dwell_san_s;
                  low_r   <= iLow;
                  high_r  <= high_san_s;
                  step_r  <= step_san_s;
               end else begin
                  start_r <= 1'b0;
               end
            end
            ST_RUN: begin
               if (!iEnable) begin
                  count_r <= DWELL_ZERO;
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else if (count_r == dwell_r - DWELL_ONE) begin
                  count_r    <= DWELL_ZERO;
                  v_r        <= next_v_s;
                  dir_down_r <= next_dir_down_s;
                  duty_r     <= pack_s;
                  valid_r    <= 1'b1;
                  period_r   <= next_period_s;
                  state_r    <= ST_WAIT_ACK;
               end else begin
                  count_r <= count_r + DWELL_ONE;
               end
            end
            ST_WAIT_ACK: begin
               // A pending update is only retired by an accept, even when disabling.
               if (iReady) begin
                  valid_r <= 1'b0;
                  count_r <= DWELL_ZERO;
                  if (iEnable) begin
                     state_r <= ST_RUN;
                     busy_r  <= 1'b1;
                  end else begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  valid_r <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               start_r <= 1'b0;
               valid_r <= 1'b0;
               busy_r  <= 1'b0;
               count_r <= DWELL_ZERO;
            end
         endcase
      end
   end

   assign oDuty   = duty_r;
   assign oValid  = valid_r;
   assign oPeriod = period_r;
   assign oBusy   = busy_r;

endmodule
